sync_fifo_ctrl: RTL

// - Pointer/flag controller turning the 128x8 simple dual-port RAM into a synchronous FIFO.
// - Sits directly upstream of the RAM: converts push/pop requests into RAM wr_en/wr_addr/wr_data and rd_en/rd_addr.
// - Returns RAM read data to the consumer with a valid strobe.
// - Provides full, empty, almost-full/almost-empty flags and an occupancy count.

---
 rtl/sync_fifo_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: pointer and flag controller that turns a 2**AW x DW simple
// dual-port RAM (registered read, 1-cycle latency) into a synchronous FIFO.
// Push/pop requests become RAM write/read strobes. Full, empty, almost-full,
// almost-empty and occupancy are kept registered, so no flag has a
// combinational path from the request inputs.
// Optional build macro SYNC_FIFO_ERR_FLAGS_EN adds the sticky overflow_o and
// underflow_o outputs.
module sync_fifo_ctrl #(
    parameter int DW            = 8,
    parameter int AW            = 7,
    parameter int AFULL_THRESH  = 120,
    parameter int AEMPTY_THRESH = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    output logic          full_o,
    output logic          almost_full_o,
    input  logic          pop_i,
    output logic [DW-1:0] pop_data_o,
    output logic          pop_valid_o,
    output logic          empty_o,
    output logic          almost_empty_o,
    output logic [AW:0]   count_o,
    output logic          ram_wr_en_o,
    output logic [AW-1:0] ram_wr_addr_o,
    output logic [DW-1:0] ram_wr_data_o,
    output logic          ram_rd_en_o,
    output logic [AW-1:0] ram_rd_addr_o,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output logic          overflow_o,
    output logic          underflow_o,
`endif
    input  logic [DW-1:0] ram_rd_data_i
);

    // Pointers carry one extra wrap bit, so wr - rd gives occupancy 0..DEPTH.
    typedef logic [AW:0] ptr_t;

    localparam ptr_t DEPTH      = ptr_t'(2 ** AW);
    localparam ptr_t AFULL_LVL  = ptr_t'(AFULL_THRESH);
    localparam ptr_t AEMPTY_LVL = ptr_t'(AEMPTY_THRESH);

    ptr_t wr_ptr_q, rd_ptr_q;
    ptr_t wr_ptr_d, rd_ptr_d, count_d;
    logic push_acc, pop_acc;
    logic full_q, almost_full_q, empty_q, almost_empty_q;
    logic pop_valid_q;

    // Accept requests against the registered flags and compute next pointers.
    always_comb begin
        // NOTE: every always_comb output gets a value before any condition,
        // so no path can leave it unassigned and infer a latch.
        push_acc = push_i & ~full_q;
        pop_acc  = pop_i & ~empty_q;
        wr_ptr_d = wr_ptr_q + ptr_t'(push_acc);
        rd_ptr_d = rd_ptr_q + ptr_t'(pop_acc);
        count_d  = wr_ptr_d - rd_ptr_d;
    end

    // Pointer, flag and read-valid state; flags derive from next occupancy.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            pop_valid_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            full_q         <= (count_d == DEPTH);
            almost_full_q  <= (count_d >= AFULL_LVL);
            empty_q        <= (count_d == '0);
            almost_empty_q <= (count_d <= AEMPTY_LVL);
            pop_valid_q    <= pop_acc;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    // Sticky error flags: set on any rejected request, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_i && full_q)  overflow_q  <= 1'b1;
            if (pop_i  && empty_q) underflow_q <= 1'b1;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`endif

    assign ram_wr_en_o    = push_acc;
    assign ram_wr_addr_o  = wr_ptr_q[AW-1:0];
    assign ram_wr_data_o  = push_data_i;
    assign ram_rd_en_o    = pop_acc;
    assign ram_rd_addr_o  = rd_ptr_q[AW-1:0];

    // The RAM registers its read data, so it lines up with pop_valid_q.
    assign pop_data_o     = ram_rd_data_i;
    assign pop_valid_o    = pop_valid_q;

    assign count_o        = wr_ptr_q - rd_ptr_q;
    assign full_o         = full_q;
    assign almost_full_o  = almost_full_q;
    assign empty_o        = empty_q;
    assign almost_empty_o = almost_empty_q;

endmodule
